// File: rtl/lanectrl_tx_dly_seq_if.sv
// Command handshake and delay-line control bundle between the fabric-side
// sequencer (slave) and whatever drives commands and the out-of-range flag (master).
interface lanectrl_tx_dly_seq_if #(
  parameter int unsigned TAP_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [TAP_W-1:0] cmd_tap;
  logic             tx_delay_line_out_of_range;
  logic             delay_line_sel;
  logic             delay_line_load;
  logic             delay_line_direction;
  logic             delay_line_move;
  logic             hs_io_clk_pause;
  logic [TAP_W-1:0] cur_tap;
  logic             busy;
  logic             done;
  logic             err_oor;

  modport master (
    output cmd_valid, cmd_load, cmd_tap, tx_delay_line_out_of_range,
    input  cmd_ready, delay_line_sel, delay_line_load, delay_line_direction,
           delay_line_move, hs_io_clk_pause, cur_tap, busy, done, err_oor
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_tap, tx_delay_line_out_of_range,
    output cmd_ready, delay_line_sel, delay_line_load, delay_line_direction,
           delay_line_move, hs_io_clk_pause, cur_tap, busy, done, err_oor
  );
endinterface

// File: rtl/lanectrl_tx_dly_seq.sv
// TX DQS delay-line sequencer: accepts "go to tap" / "reload default" commands,
// brackets every delay update with HS_IO_CLK_PAUSE, steps one tap per MOVE pulse
// and aborts on out-of-range. All outputs are registered.
// Optional build macro LANECTRL_TX_DLY_STEP_CNT_EN adds step_cnt_o, a saturating
// count of MOVE pulses cleared by reset and by each LOAD command.
module lanectrl_tx_dly_seq #(
  parameter int unsigned TAP_W       = 8,
  parameter int unsigned INIT_TAP    = 1,
  parameter int unsigned MAX_TAP     = 255,
  parameter int unsigned MOVE_GAP    = 4,
  parameter int unsigned PAUSE_LEAD  = 3,
  parameter int unsigned PAUSE_TRAIL = 3
) (
  input logic                  FAB_CLK,
  input logic                  RESET,
  lanectrl_tx_dly_seq_if.slave bus
`ifdef LANECTRL_TX_DLY_STEP_CNT_EN
  ,
  output logic [15:0]          step_cnt_o
`endif
);

  localparam logic [TAP_W-1:0] TapInit   = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TapMax    = TAP_W'(MAX_TAP);
  localparam logic [15:0]      LeadLast  = 16'(PAUSE_LEAD - 1);
  localparam logic [15:0]      TrailLast = 16'(PAUSE_TRAIL - 1);
  localparam logic [15:0]      GapLast   = 16'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPausePre,
    StLoad,
    StMove,
    StGap,
    StPausePost,
    StDone
  } state_e;

  state_e           state_q;
  logic [15:0]      cnt_q;
  logic [TAP_W-1:0] target_q;
  logic             load_cmd_q;
  logic [TAP_W-1:0] cur_q;
  logic             ready_q, busy_q, sel_q, pause_q, dir_q, move_q, load_q, done_q, err_q;

  logic [TAP_W-1:0] tgt;
  logic [TAP_W-1:0] tap_step;

  // Clamp the requested tap and compute the next stepped tap (saturating, never wraps).
  always_comb begin
    tgt = (bus.cmd_tap > TapMax) ? TapMax : bus.cmd_tap;
    tap_step = cur_q;
    if (dir_q) begin
      if (cur_q != TapMax) tap_step = cur_q + 1'b1;
    end else if (cur_q != '0) begin
      tap_step = cur_q - 1'b1;
    end
  end

  // Command FSM; outputs are written alongside the state they belong to.
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      target_q   <= TapInit;
      load_cmd_q <= 1'b0;
      cur_q      <= TapInit;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      sel_q      <= 1'b0;
      pause_q    <= 1'b0;
      dir_q      <= 1'b1;
      move_q     <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      move_q <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            load_cmd_q <= bus.cmd_load;
            target_q   <= tgt;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            if (!bus.cmd_load && (tgt == cur_q)) begin
              // Already there: skip the pause entirely.
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPausePre;
              pause_q <= 1'b1;
              sel_q   <= 1'b1;
              dir_q   <= (tgt > cur_q);
            end
          end
        end
        StPausePre: begin
          if (cnt_q == LeadLast) begin
            cnt_q <= '0;
            if (load_cmd_q) begin
              state_q <= StLoad;
              load_q  <= 1'b1;
              cur_q   <= TapInit;
            end else begin
              state_q <= StMove;
              move_q  <= 1'b1;
              cur_q   <= tap_step;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StLoad: begin
          state_q <= StPausePost;
          cnt_q   <= '0;
        end
        StMove: begin
          state_q <= StGap;
          cnt_q   <= '0;
        end
        StGap: begin
          if (bus.tx_delay_line_out_of_range) begin
            err_q   <= 1'b1;
            state_q <= StPausePost;
            cnt_q   <= '0;
          end else if (cnt_q == GapLast) begin
            cnt_q <= '0;
            if (cur_q != target_q) begin
              state_q <= StMove;
              move_q  <= 1'b1;
              cur_q   <= tap_step;
            end else begin
              state_q <= StPausePost;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StPausePost: begin
          if (cnt_q == TrailLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            pause_q <= 1'b0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LANECTRL_TX_DLY_STEP_CNT_EN
  logic [15:0] step_cnt_q;

  // Saturating MOVE pulse counter, restarted by every LOAD pulse.
  always_ff @(posedge FAB_CLK) begin
    if (RESET || load_q) begin
      step_cnt_q <= '0;
    end else if (move_q && (step_cnt_q != 16'hFFFF)) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign step_cnt_o = step_cnt_q;
`endif

  assign bus.cmd_ready            = ready_q;
  assign bus.busy                 = busy_q;
  assign bus.delay_line_sel       = sel_q;
  assign bus.hs_io_clk_pause      = pause_q;
  assign bus.delay_line_direction = dir_q;
  assign bus.delay_line_move      = move_q;
  assign bus.delay_line_load      = load_q;
  assign bus.done                 = done_q;
  assign bus.err_oor              = err_q;
  assign bus.cur_tap              = cur_q;

endmodule
